alu_operand_issue: RTL and testbench

//  Operand-fetch/issue and write-back stage wrapped around the combinational 8-bit ALU (AND/OR/ADD/SUB).

---
 rtl/alu_operand_issue_if.sv | 24 ++
 rtl/alu_operand_issue.sv | 112 +++++++++++
 tb/tb_alu_operand_issue.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_operand_issue_if.sv
// rtl/alu_operand_issue_if.sv - op request bundle between requester and the operand issue stage
interface alu_operand_issue_if #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_op;
   logic [REG_AW-1:0] in_rs1;
   logic [REG_AW-1:0] in_rs2;
   logic              in_imm_en;
   logic [DATA_W-1:0] in_imm;
   logic [REG_AW-1:0] in_rd;

   modport master (
      output in_valid, in_op, in_rs1, in_rs2, in_imm_en, in_imm, in_rd,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_op, in_rs1, in_rs2, in_imm_en, in_imm, in_rd,
      output in_ready
   );
endinterface

// File: rtl/alu_operand_issue.sv
// rtl/alu_operand_issue.sv - operand fetch, issue and write-back around a combinational ALU
// Ops are serialized IDLE -> EXEC -> WB, so the register file never sees a hazard.
module alu_operand_issue #(
   parameter int DATA_W = 8,
   parameter int NREG   = 8,
   parameter int REG_AW = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_operand_issue_if.slave   req,
   output logic [DATA_W-1:0]    alu_src_a,
   output logic [DATA_W-1:0]    alu_src_b,
   output logic [1:0]           alu_ctrl,
   input  logic [DATA_W-1:0]    alu_result,
   input  logic                 alu_zero,
   output logic                 wb_valid,
   output logic [REG_AW-1:0]    wb_rd,
   output logic [DATA_W-1:0]    wb_data,
   output logic                 zero_flag,
   input  logic [REG_AW-1:0]    dbg_raddr,
   output logic [DATA_W-1:0]    dbg_rdata
);
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [DATA_W-1:0] src_a_q, src_a_d;
   logic [DATA_W-1:0] src_b_q, src_b_d;
   logic [1:0]        ctrl_q, ctrl_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              wb_valid_q, wb_valid_d;
   logic              zero_cap_q, zero_cap_d;
   logic              zero_flag_q, zero_flag_d;

   assign req.in_ready = rst_n && (state_q == S_IDLE);

   always_comb begin
      state_d     = state_q;
      regs_d      = regs_q;
      src_a_d     = src_a_q;
      src_b_d     = src_b_q;
      ctrl_d      = ctrl_q;
      rd_d        = rd_q;
      wb_data_d   = wb_data_q;
      wb_valid_d  = 1'b0;
      zero_cap_d  = zero_cap_q;
      zero_flag_d = zero_flag_q;
      case (state_q)
         S_IDLE: begin
            if (req.in_valid) begin
               src_a_d = regs_q[req.in_rs1];
               src_b_d = req.in_imm_en ? req.in_imm : regs_q[req.in_rs2];
               ctrl_d  = req.in_op;
               rd_d    = req.in_rd;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            wb_data_d  = alu_result;
            zero_cap_d = alu_zero;
            wb_valid_d = 1'b1;
            state_d    = S_WB;
         end
         S_WB: begin
            // r0 is never written so it reads back as zero without a read-side mux
            if (rd_q != '0) begin
               regs_d[rd_q] = wb_data_q;
            end
            zero_flag_d = zero_cap_q;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         regs_q      <= '{default: '0};
         src_a_q     <= '0;
         src_b_q     <= '0;
         ctrl_q      <= '0;
         rd_q        <= '0;
         wb_data_q   <= '0;
         wb_valid_q  <= 1'b0;
         zero_cap_q  <= 1'b0;
         zero_flag_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         regs_q      <= regs_d;
         src_a_q     <= src_a_d;
         src_b_q     <= src_b_d;
         ctrl_q      <= ctrl_d;
         rd_q        <= rd_d;
         wb_data_q   <= wb_data_d;
         wb_valid_q  <= wb_valid_d;
         zero_cap_q  <= zero_cap_d;
         zero_flag_q <= zero_flag_d;
      end
   end

   assign alu_src_a = src_a_q;
   assign alu_src_b = src_b_q;
   assign alu_ctrl  = ctrl_q;
   assign wb_valid  = wb_valid_q;
   assign wb_rd     = rd_q;
   assign wb_data   = wb_data_q;
   assign zero_flag = zero_flag_q;
   assign dbg_rdata = regs_q[dbg_raddr];
endmodule

// File: tb/tb_alu_operand_issue.sv
// tb/tb_alu_operand_issue.sv - scoreboard bench for alu_operand_issue with a behavioural ALU
module tb_alu_operand_issue;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] alu_src_a, alu_src_b, alu_result, wb_data, dbg_rdata;
   logic [1:0] alu_ctrl;
   logic       alu_zero, wb_valid, zero_flag;
   logic [2:0] wb_rd, dbg_raddr;

   int checks   = 0;
   int failures = 0;
   logic [10:0] exp_q[$];

   alu_operand_issue_if #(.DATA_W(8), .REG_AW(3)) req_if ();

   alu_operand_issue #(.DATA_W(8), .NREG(8), .REG_AW(3)) dut (
      .clk(clk), .rst_n(rst_n), .req(req_if.slave),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .zero_flag(zero_flag), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
   );

   always #5 clk = ~clk;

   // external combinational ALU
   always_comb begin
      alu_result = 8'h00;
      case (alu_ctrl)
         2'b00: alu_result = alu_src_a & alu_src_b;
         2'b01: alu_result = alu_src_a | alu_src_b;
         2'b10: alu_result = alu_src_a + alu_src_b;
         2'b11: alu_result = alu_src_a - alu_src_b;
         default: alu_result = 8'h00;
      endcase
   end
   assign alu_zero = (alu_result == 8'h00);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // monitor: every write-back pulse is matched against the oldest expectation
   always @(negedge clk) begin
      if (wb_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("wb_unexpected", 1, 0);
         end else begin
            logic [10:0] e;
            e = exp_q.pop_front();
            chk("wb_rd", {29'd0, wb_rd}, {29'd0, e[10:8]});
            chk("wb_data", {24'd0, wb_data}, {24'd0, e[7:0]});
         end
      end
   end

   task automatic dbg_chk(input string name, input logic [2:0] a, input logic [7:0] v);
      dbg_raddr = a;
      #1;
      chk(name, {24'd0, dbg_rdata}, {24'd0, v});
   endtask

   task automatic do_op(input string name, input logic [1:0] op, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic ie, input logic [7:0] imm,
                        input logic [2:0] rd, input logic [7:0] exp, input logic exp_z);
      int n = 0;
      @(negedge clk);
      while (req_if.in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (req_if.in_ready !== 1'b1) begin
         chk({name, "_ready_timeout"}, 0, 1);
         return;
      end
      req_if.in_valid  = 1'b1;
      req_if.in_op     = op;
      req_if.in_rs1    = rs1;
      req_if.in_rs2    = rs2;
      req_if.in_imm_en = ie;
      req_if.in_imm    = imm;
      req_if.in_rd     = rd;
      exp_q.push_back({rd, exp});
      @(negedge clk);
      req_if.in_valid = 1'b0;
      chk({name, "_exec_nowb"}, {31'd0, wb_valid}, 0);
      @(negedge clk);
      chk({name, "_wb_latency"}, {31'd0, wb_valid}, 1);
      @(negedge clk);
      chk({name, "_zero_flag"}, {31'd0, zero_flag}, {31'd0, exp_z});
      dbg_chk({name, "_dbg_rd"}, rd, (rd == 3'd0) ? 8'h00 : exp);
   endtask

   initial begin
      int acc;
      rst_n = 1'b0;
      dbg_raddr = 3'd0;
      req_if.in_valid = 1'b0; req_if.in_op = 2'b00; req_if.in_rs1 = '0; req_if.in_rs2 = '0;
      req_if.in_imm_en = 1'b0; req_if.in_imm = '0; req_if.in_rd = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {31'd0, req_if.in_ready}, 0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 0);
      chk("rst_zero_flag", {31'd0, zero_flag}, 0);
      for (int i = 0; i < 8; i++) dbg_chk("rst_dbg", 3'(i), 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, req_if.in_ready}, 1);

      do_op("or_imm_r1", 2'b01, 3'd0, 3'd0, 1'b1, 8'h83, 3'd1, 8'h83, 1'b0);
      do_op("or_imm_r2", 2'b01, 3'd0, 3'd0, 1'b1, 8'h81, 3'd2, 8'h81, 1'b0);
      do_op("add_wrap",  2'b10, 3'd1, 3'd2, 1'b0, 8'h00, 3'd3, 8'h04, 1'b0);
      do_op("sub",       2'b11, 3'd1, 3'd2, 1'b0, 8'h00, 3'd3, 8'h02, 1'b0);
      do_op("and",       2'b00, 3'd1, 3'd2, 1'b0, 8'h00, 3'd3, 8'h81, 1'b0);
      do_op("or",        2'b01, 3'd1, 3'd2, 1'b0, 8'h00, 3'd3, 8'h83, 1'b0);
      do_op("sub_self",  2'b11, 3'd1, 3'd1, 1'b0, 8'h00, 3'd4, 8'h00, 1'b1);
      do_op("add_clrz",  2'b10, 3'd1, 3'd2, 1'b0, 8'h00, 3'd4, 8'h04, 1'b0);
      do_op("add_r0",    2'b10, 3'd1, 3'd2, 1'b0, 8'h00, 3'd0, 8'h04, 1'b0);
      do_op("rd_eq_rs",  2'b10, 3'd3, 3'd3, 1'b0, 8'h00, 3'd3, 8'h06, 1'b0);

      // in_valid held continuously: one accept every third cycle
      @(negedge clk);
      req_if.in_op = 2'b10; req_if.in_rs1 = 3'd1; req_if.in_rs2 = 3'd2;
      req_if.in_imm_en = 1'b0; req_if.in_rd = 3'd5; req_if.in_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 9; i++) begin
         if (req_if.in_ready === 1'b1) begin
            acc++;
            exp_q.push_back({3'd5, 8'h04});
         end
         @(negedge clk);
      end
      req_if.in_valid = 1'b0;
      chk("held_accepts", acc, 3);
      repeat (3) @(negedge clk);
      dbg_chk("held_dbg_r5", 3'd5, 8'h04);

      // reset while the op is in EXEC: aborted, no write-back
      req_if.in_op = 2'b10; req_if.in_rs1 = 3'd1; req_if.in_rs2 = 3'd2; req_if.in_rd = 3'd6;
      req_if.in_valid = 1'b1;
      @(negedge clk);
      req_if.in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_wb_valid", {31'd0, wb_valid}, 0);
      chk("abort_in_ready", {31'd0, req_if.in_ready}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_wb_valid2", {31'd0, wb_valid}, 0);
      chk("abort_idle", {31'd0, req_if.in_ready}, 1);
      dbg_chk("abort_dbg_r6", 3'd6, 8'h00);
      dbg_chk("abort_dbg_r1", 3'd1, 8'h00);

      do_op("post_abort", 2'b01, 3'd0, 3'd0, 1'b1, 8'h55, 3'd7, 8'h55, 1'b0);
      repeat (4) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
